regfile_param_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Provides WIDTH x DEPTH storage, NREAD combinational read ports and one synchronous write port.
- x0 is hard-wired to zero. Reset is a multi-cycle clear sweep that seeds the gp register.
- Adds a per-register busy scoreboard so the issue stage can detect pending writes without external tracking.

---
 rtl/regfile_param_sb.sv | 65 ++++++
 tb/tb_regfile_param_sb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/regfile_param_sb.sv
// regfile_param_sb: WIDTH x DEPTH register file with NREAD read ports, clear sweep, busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_param_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int GP_INDEX = 3,
  parameter logic [WIDTH-1:0] GP_INIT = 'h400
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREAD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NREAD*WIDTH-1:0]           rd_data,
  output logic [NREAD-1:0]                 rs_busy,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             busy_set,
  input  logic [$clog2(DEPTH)-1:0]         busy_addr,
  output logic                             ready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [AW:0] cnt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic wr_ok, set_ok;
  assign wr_ok = state == READY && wr_en && wr_addr != '0;
  assign set_ok = state == READY && busy_set && busy_addr != '0;
  assign ready = state == READY;
  // sweep ends on the edge that clears the last register
  always_comb begin
    state_nx = (state == CLEAR && cnt == (AW+1)'(DEPTH-1)) ? READY : state;
  end
  // state, sweep counter and busy bits; a same-edge set overrides the write's clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      busy <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      if (wr_ok) busy[wr_addr] <= 1'b0;
      if (set_ok) busy[busy_addr] <= 1'b1;
    end
  end
  // storage: sweep writes seed/zero, otherwise writeback
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) regs[cnt[AW-1:0]] <= (cnt == (AW+1)'(GP_INDEX)) ? GP_INIT : '0;
    else if (!rst && wr_ok) regs[wr_addr] <= wr_data;
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic byp;
    assign a = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign byp = wr_ok && wr_addr == a;
`else
    assign byp = 1'b0;
`endif
    assign rd_data[i*WIDTH +: WIDTH] = (state != READY || a == '0) ? '0 : byp ? wr_data : regs[a];
    assign rs_busy[i] = state == READY && a != '0 && !byp && busy[a];
  end
endmodule

// File: tb/tb_regfile_param_sb.sv
// tb_regfile_param_sb: scoreboard bench for regfile_param_sb with default parameters
module tb_regfile_param_sb;
  logic clk = 0;
  logic rst = 1;
  logic [9:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0] rs_busy;
  logic wr_en = 0;
  logic [4:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic busy_set = 0;
  logic [4:0] busy_addr = '0;
  logic ready;
  typedef struct packed {
    logic [63:0] d;
    logic [1:0] b;
    logic r;
  } exp_t;
  exp_t exp_q[$];
  string name_q[$];
  logic chk_v = 0;
  int checks = 0;
  int errors = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif

  regfile_param_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rs_busy(rs_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  // monitor: pops the expectation for every cycle the stimulus marks for checking
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
        exp_t e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (rd_data !== e.d || rs_busy !== e.b || ready !== e.r) begin
          errors++;
          $display("FAIL %s: got data=%h busy=%b ready=%b expected data=%h busy=%b ready=%b",
                   n, rd_data, rs_busy, ready, e.d, e.b, e.r);
        end
      end
    end
  end

  task automatic cyc(input string n, input logic [31:0] d1, input logic [31:0] d0,
                     input logic [1:0] b, input logic r);
    exp_t e;
    e.d = {d1, d0};
    e.b = b;
    e.r = r;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_v = 1;
    @(posedge clk);
    #1;
    chk_v = 0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    rd_addr = {a1, a0};
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    rd(5'd4, 5'd3);
    wr_en = 1; wr_addr = 5'd4; wr_data = 32'h1;
    busy_set = 1; busy_addr = 5'd4;
    for (int k = 0; k < 32; k++) cyc("sweep", 0, 0, 2'b00, 0);
    wr_en = 0; busy_set = 0;
    rd(5'd5, 5'd3);
    cyc("gp_seed", 0, 32'h400, 2'b00, 1);
    rd(5'd4, 5'd4);
    cyc("clear_gating_r4", 0, 0, 2'b00, 1);
    rd(5'd0, 5'd7);
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    cyc("write_r7", 0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00, 1);
    wr_addr = 5'd0; wr_data = 32'h1234;
    cyc("write_r0", 0, 32'hDEADBEEF, 2'b00, 1);
    wr_en = 0;
    cyc("x0_read", 0, 32'hDEADBEEF, 2'b00, 1);
    rd(5'd9, 5'd9);
    busy_set = 1; busy_addr = 5'd9;
    cyc("busy_set_edge", 0, 0, 2'b00, 1);
    busy_set = 0;
    cyc("busy_r9", 0, 0, 2'b11, 1);
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'd5;
    cyc("wb_r9", BYP ? 32'd5 : 32'd0, BYP ? 32'd5 : 32'd0, BYP ? 2'b00 : 2'b11, 1);
    wr_en = 0;
    cyc("busy_cleared", 32'd5, 32'd5, 2'b00, 1);
    wr_en = 1; wr_data = 32'd6; busy_set = 1;
    cyc("set_and_wb", BYP ? 32'd6 : 32'd5, BYP ? 32'd6 : 32'd5, 2'b00, 1);
    wr_en = 0; busy_set = 0;
    cyc("set_wins", 32'd6, 32'd6, 2'b11, 1);
    rd(5'd0, 5'd0);
    busy_set = 1; busy_addr = 5'd0;
    cyc("busy_x0_a", 0, 0, 2'b00, 1);
    busy_set = 0;
    cyc("busy_x0_b", 0, 0, 2'b00, 1);
    rd(5'd7, 5'd12);
    wr_en = 1; wr_addr = 5'd12; wr_data = 32'hA5A5A5A5;
    cyc("bypass_r12", 32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0, 2'b00, 1);
    wr_en = 0;
    cyc("after_r12", 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 1);
    rst = 1;
    cyc("pre_reset", 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 1);
    rst = 0;
    for (int k = 0; k < 10; k++) cyc("sweep_a", 0, 0, 2'b00, 0);
    rst = 1;
    cyc("mid_reset", 0, 0, 2'b00, 0);
    rst = 0;
    for (int k = 0; k < 32; k++) cyc("sweep_b", 0, 0, 2'b00, 0);
    rd(5'd3, 5'd7);
    cyc("resweep_done", 32'h400, 0, 2'b00, 1);
    rd(5'd9, 5'd12);
    cyc("resweep_busy", 0, 0, 2'b00, 1);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
